// File: rtl/spike_packet_generator.sv
// Spike packet generator: thresholds float32 membrane potentials at each timestep
// boundary, latches the firing set and streams firing neuron addresses over valid/ready.
module spike_packet_generator #(
   parameter int NUM_NEURONS = 10,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          clear,
   input  logic [DATA_W-1:0]             threshold,
   input  logic [NUM_NEURONS*DATA_W-1:0] membrane_potentials,
   input  logic [NUM_NEURONS*ADDR_W-1:0] neuron_addresses,
   output logic                          spike_valid,
   output logic [ADDR_W-1:0]             source_address,
   input  logic                          spike_ready,
   output logic [NUM_NEURONS-1:0]        spike_vector,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [NUM_NEURONS-1:0] ONE_N = {{(NUM_NEURONS-1){1'b0}}, 1'b1};

   // IEEE-754 single-precision a >= b; NaN never fires, +0 and -0 compare equal
   function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
      logic a_nan;
      logic b_nan;
      logic both_zero;
      a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
      if (a_nan || b_nan) begin
         fp_ge = 1'b0;
      end else if (both_zero) begin
         fp_ge = 1'b1;
      end else if (a[31] != b[31]) begin
         fp_ge = ~a[31];
      end else if (!a[31]) begin
         fp_ge = (a[30:0] >= b[30:0]);
      end else begin
         fp_ge = (a[30:0] <= b[30:0]);
      end
   endfunction

   logic [1:0]             state_q, state_d;
   logic [NUM_NEURONS-1:0] pending_q, pending_d;
   logic [NUM_NEURONS-1:0] spike_vector_q, spike_vector_d;
   logic                   spike_valid_q, spike_valid_d;
   logic [ADDR_W-1:0]      source_address_q, source_address_d;
   logic                   done_q, done_d;
   logic                   overrun_q, overrun_d;

   logic [NUM_NEURONS-1:0] fire_s;
   logic [NUM_NEURONS-1:0] lowest_s;
   logic [ADDR_W-1:0]      addr_sel_s;
   logic                   out_free_s;

   // Per-neuron threshold comparison
   always_comb begin
      fire_s = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         fire_s[i] = fp_ge(membrane_potentials[i*DATA_W +: DATA_W], threshold);
      end
   end

   // Lowest pending bit isolated as one-hot, so packets leave in ascending index order
   assign lowest_s = pending_q & (~pending_q + ONE_N);

   // Address mux driven by the one-hot lowest pending bit
   always_comb begin
      addr_sel_s = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (lowest_s[i]) begin
            addr_sel_s = addr_sel_s | neuron_addresses[i*ADDR_W +: ADDR_W];
         end else begin
            addr_sel_s = addr_sel_s;
         end
      end
   end

   assign out_free_s = !spike_valid_q || spike_ready;

   // Next-state and output-register logic
   always_comb begin
      state_d          = state_q;
      pending_d        = pending_q;
      spike_vector_d   = spike_vector_q;
      spike_valid_d    = spike_valid_q;
      source_address_d = source_address_q;
      overrun_d        = overrun_q;
      done_d           = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (clear) begin
               spike_vector_d = fire_s;
               pending_d      = fire_s;
               state_d        = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (clear) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            if (out_free_s) begin
               if (pending_q != '0) begin
                  source_address_d = addr_sel_s;
                  spike_valid_d    = 1'b1;
                  pending_d        = pending_q & ~lowest_s;
               end else begin
                  spike_valid_d = 1'b0;
                  state_d       = ST_DONE;
               end
            end else begin
               spike_valid_d = spike_valid_q;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            pending_d     = '0;
            spike_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q          <= ST_IDLE;
         pending_q        <= '0;
         spike_vector_q   <= '0;
         spike_valid_q    <= 1'b0;
         source_address_q <= '0;
         done_q           <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         pending_q        <= pending_d;
         spike_vector_q   <= spike_vector_d;
         spike_valid_q    <= spike_valid_d;
         source_address_q <= source_address_d;
         done_q           <= done_d;
         overrun_q        <= overrun_d;
      end
   end

   assign spike_valid    = spike_valid_q;
   assign source_address = source_address_q;
   assign spike_vector   = spike_vector_q;
   assign busy           = (state_q == ST_SCAN);
   assign done           = done_q;
   assign overrun        = overrun_q;

endmodule
